// File: rtl/cxd_input_fifo.sv
// (CX,D) input buffer for the MQ coder: DEPTH-entry circular store, 1-cycle push-to-output latency, flush ordered after stored symbols.
// Backpressure: in_ready drops when full or while a flush waits for the drain; the head is held stable until out_ready.
module cxd_input_fifo #(
  parameter int CX_W  = 5,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CX_W-1:0]  CXIn,
  input  logic             DIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CX_W-1:0]  CXOut,
  output logic             DOut,
  output logic             flush_forward,
  output logic             rst_forward,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [CX_W-1:0] cx;
    logic            d;
  } sym_t;

  sym_t             mem [DEPTH];
  sym_t             head;
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [LVL_W-1:0] count;
  logic             flush_pending;
  logic             push;
  logic             pop;
  logic             flush_fire;

  // No pass-through when full: in_ready ignores out_ready.
  assign in_ready   = (count < FULL_LVL) && !flush_pending;
  assign out_valid  = (count != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign flush_fire = flush_pending && (count == '0);

  assign head  = mem[rp];
  assign CXOut = head.cx;
  assign DOut  = head.d;
  assign level = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= {CXIn, DIn};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + PTR_W'(1);
      end
      if (pop) begin
        rp <= rp + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A flush landing on the completion edge is kept pending so it yields its own pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_pending <= 1'b0;
      flush_forward <= 1'b0;
    end else begin
      flush_pending <= flush || (flush_pending && !flush_fire);
      flush_forward <= flush_fire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_forward <= 1'b1;
    end else begin
      rst_forward <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cxd_input_fifo.sv
// Directed bench for cxd_input_fifo: vector table for fill/drain/empty flush, hand sequences for the multi-cycle cases.
module tb_cxd_input_fifo;
  localparam int CX_W  = 5;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             DIn = 1'b0;
  logic             out_ready = 1'b0;
  logic [CX_W-1:0]  CXIn = '0;
  logic             in_ready;
  logic             out_valid;
  logic [CX_W-1:0]  CXOut;
  logic             DOut;
  logic             flush_forward;
  logic             rst_forward;
  logic [LVL_W-1:0] level;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cxd_input_fifo #(.CX_W(CX_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .CXIn         (CXIn),
    .DIn          (DIn),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .CXOut        (CXOut),
    .DOut         (DOut),
    .flush_forward(flush_forward),
    .rst_forward  (rst_forward),
    .level        (level)
  );

  typedef struct {
    logic rst;
    logic flush;
    logic in_valid;
    int   cx;
    logic d;
    logic out_ready;
    logic e_ir;
    logic e_ov;
    int   e_cx;
    logic e_d;
    int   e_lvl;
    logic e_ff;
    logic e_rf;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic r, input logic fl, input logic iv, input int cx,
                              input logic d, input logic orr, input logic ir, input logic ov,
                              input int ecx, input logic ed, input int lvl, input logic ff,
                              input logic rf);
    vec_t v;
    v.rst = r;  v.flush = fl; v.in_valid = iv; v.cx = cx; v.d = d; v.out_ready = orr;
    v.e_ir = ir; v.e_ov = ov; v.e_cx = ecx; v.e_d = ed; v.e_lvl = lvl; v.e_ff = ff; v.e_rf = rf;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive at the falling edge, then let combinational outputs settle before sampling.
  task automatic drive(input logic fl, input logic iv, input int cx, input logic d, input logic orr);
    @(negedge clk);
    flush     = fl;
    in_valid  = iv;
    CXIn      = CX_W'(cx);
    DIn       = d;
    out_ready = orr;
    #1;
  endtask

  initial begin
    int   ff_cnt;
    int   pops;
    int   got [4];

    // rst, flush, in_valid, cx, d, out_ready | in_ready, out_valid, cx, d, level, flush_fwd, rst_fwd
    vecs[0]  = mk(1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 1);
    vecs[1]  = mk(0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 1, 2, 1, 0,  1, 1, 1, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 1, 3, 0, 0,  1, 1, 1, 0, 2, 0, 0);
    vecs[4]  = mk(0, 0, 1, 4, 1, 0,  1, 1, 1, 0, 3, 0, 0);
    vecs[5]  = mk(0, 0, 1, 5, 0, 0,  0, 1, 1, 0, 4, 0, 0);
    vecs[6]  = mk(0, 0, 1, 5, 0, 1,  0, 1, 1, 0, 4, 0, 0);
    vecs[7]  = mk(0, 0, 1, 5, 0, 1,  1, 1, 2, 1, 3, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1,  1, 1, 3, 0, 3, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 1,  1, 1, 4, 1, 2, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 1,  1, 1, 5, 0, 1, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      flush     = vecs[i].flush;
      in_valid  = vecs[i].in_valid;
      CXIn      = CX_W'(vecs[i].cx);
      DIn       = vecs[i].d;
      out_ready = vecs[i].out_ready;
      #1;
      chk($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vecs[i].e_ir));
      chk($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].e_ov));
      chk($sformatf("v%0d_level", i), int'(level), vecs[i].e_lvl);
      chk($sformatf("v%0d_flush_fwd", i), int'(flush_forward), int'(vecs[i].e_ff));
      chk($sformatf("v%0d_rst_fwd", i), int'(rst_forward), int'(vecs[i].e_rf));
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_cx", i), int'(CXOut), vecs[i].e_cx);
        chk($sformatf("v%0d_d", i), int'(DOut), int'(vecs[i].e_d));
      end
    end

    // Steady push+pop at level 2 across several pointer wraps.
    drive(0, 1, 10, 0, 0);
    drive(0, 1, 11, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 12 + i, 1'((12 + i) % 2), 1);
      chk($sformatf("pp%0d_level", i), int'(level), 2);
      chk($sformatf("pp%0d_cx", i), int'(CXOut), 10 + i);
      chk($sformatf("pp%0d_d", i), int'(DOut), (10 + i) % 2);
    end
    drive(0, 0, 0, 0, 1);
    chk("pp_tail0_cx", int'(CXOut), 20);
    chk("pp_tail0_level", int'(level), 2);
    drive(0, 0, 0, 0, 1);
    chk("pp_tail1_cx", int'(CXOut), 21);
    chk("pp_tail1_level", int'(level), 1);
    drive(0, 0, 0, 0, 0);
    chk("pp_empty_level", int'(level), 0);
    chk("pp_empty_ov", int'(out_valid), 0);

    // Full with a pop: the pop does not open in_ready in the same cycle.
    for (int i = 1; i <= 4; i++) drive(0, 1, i, 1'(i % 2), 0);
    drive(0, 1, 9, 1, 1);
    chk("full_pop_in_ready", int'(in_ready), 0);
    chk("full_pop_level", int'(level), 4);
    drive(0, 1, 9, 1, 0);
    chk("after_pop_level", int'(level), 3);
    chk("after_pop_in_ready", int'(in_ready), 1);
    chk("after_pop_cx", int'(CXOut), 2);
    drive(0, 0, 0, 0, 1);
    chk("refill_level", int'(level), 4);
    chk("drain0_cx", int'(CXOut), 2);
    drive(0, 0, 0, 0, 1);
    chk("drain1_cx", int'(CXOut), 3);
    drive(0, 0, 0, 0, 1);
    chk("drain2_cx", int'(CXOut), 4);
    drive(0, 0, 0, 0, 1);
    chk("drain3_cx", int'(CXOut), 9);
    chk("drain3_d", int'(DOut), 1);
    drive(0, 0, 0, 0, 0);
    chk("drain_level", int'(level), 0);

    // Flush with two stored symbols and a same-cycle push.
    drive(0, 1, 20, 0, 0);
    drive(0, 1, 21, 1, 0);
    drive(1, 1, 7, 1, 0);
    chk("fo_in_ready_flush_cycle", int'(in_ready), 1);
    chk("fo_level_pre", int'(level), 2);
    drive(0, 0, 0, 0, 0);
    chk("fo_in_ready_pending", int'(in_ready), 0);
    chk("fo_level_post", int'(level), 3);
    ff_cnt = 0;
    pops   = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 1);
      if (flush_forward) begin
        ff_cnt++;
        chk("fo_in_ready_during_pulse", int'(in_ready), 1);
        chk("fo_pops_before_pulse", pops, 3);
      end
      if (out_valid) begin
        if (pops < 4) got[pops] = {CXOut, DOut};
        pops++;
      end
    end
    chk("fo_pulse_cycles", ff_cnt, 1);
    chk("fo_pop_count", pops, 3);
    chk("fo_pop0", got[0], (20 << 1) | 0);
    chk("fo_pop1", got[1], (21 << 1) | 1);
    chk("fo_pop2", got[2], (7 << 1) | 1);
    drive(0, 0, 0, 0, 0);

    // Second flush while one is pending merges into a single pulse.
    drive(0, 1, 3, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("merge_in_ready_pending", int'(in_ready), 0);
    drive(1, 0, 0, 0, 0);
    ff_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 1);
      if (flush_forward) ff_cnt++;
    end
    chk("merge_pulse_cycles", ff_cnt, 1);
    drive(0, 0, 0, 0, 0);

    // Mid-cycle reset with three stored symbols and a pending flush.
    drive(0, 1, 1, 1, 0);
    drive(0, 1, 2, 0, 0);
    drive(0, 1, 3, 1, 0);
    drive(1, 0, 0, 0, 0);
    chk("rst_pre_level", int'(level), 3);
    @(negedge clk);
    flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_level", int'(level), 0);
    chk("rst_async_ov", int'(out_valid), 0);
    chk("rst_async_rst_fwd", int'(rst_forward), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_rst_fwd", int'(rst_forward), 1);
    @(posedge clk);
    #1;
    chk("rst_edge_rst_fwd", int'(rst_forward), 0);
    chk("rst_edge_in_ready", int'(in_ready), 1);
    chk("rst_edge_level", int'(level), 0);
    ff_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      if (flush_forward) ff_cnt++;
    end
    chk("rst_flush_discarded", ff_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
